// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
// Truth tables are indexed by the input vector, {a,b} for two-input gates.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable settle down-counter; expire is high in the last settle cycle.
// Counts down to zero and parks there until the next load.
module sweep_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(SETTLE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector of a gate under test in ascending order and
// checks the sampled output against EXP_TT; reports pass, count, first fail.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXP_TT = TT_NOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] in_vec,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] first_fail
);

  localparam int FW = N_IN + 1;

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] in_vec_q, in_vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;

  logic timer_load;
  logic timer_expire;
  logic mismatch;
  logic last_vec;

  assign mismatch = (y_in != EXP_TT[in_vec_q]);
  assign last_vec = &in_vec_q;

  // The timer is reloaded whenever a fresh vector enters HOLD.
  assign timer_load = !abort &&
                      (((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_SAMPLE) && !last_vec));

  sweep_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .expire(timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    in_vec_d     = in_vec_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d      = ST_HOLD;
          in_vec_d     = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (timer_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (mismatch) begin
            fail_cnt_d = fail_cnt_q + FW'(1);
            // A zero count means this is the first mismatch of the sweep.
            if (fail_cnt_q == '0) begin
              first_fail_d = in_vec_q;
            end
          end
          if (last_vec) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_cnt_d == '0);
          end else begin
            state_d  = ST_HOLD;
            in_vec_d = in_vec_q + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_vec_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      in_vec_q     <= in_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign in_vec     = in_vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sequencer for a small combinational gate under test (NOR, NAND, XOR, ...). On a start pulse it drives every input combination onto the gate in ascending binary order. For each combination it waits a programmable settle time, samples the gate output and compares it with an expected truth table. It reports pass/fail, a mismatch count and the first failing vector. It sits between a bring-up/BIST wrapper and the gate instance, replacing hand-written stimulus sequences.

## Interface

Parameters:
- N_IN, default 2: number of gate inputs; the sweep covers 2**N_IN vectors.
- SETTLE, default 1: cycles each vector is held before sampling; legal range is 1 or more.
- EXP_TT, default 4'b0001 (NOR), width 2**N_IN: bit k is the expected gate output for input vector k. In_vec[N_IN-1] is the MSB (for N_IN=2, {a,b}).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a sweep; accepted only in IDLE.
- abort  in  1  synchronous; abandons a running sweep.
- in_vec  out  N_IN  drive to the gate inputs.
- y_in  in  1  gate output.
- busy  out  1  high from the cycle after start is accepted until the sweep ends.
- done  out  1  one-cycle pulse when a sweep completes normally.
- pass  out  1  valid from done; high only if fail_cnt==0; held until the next accepted start.
- fail_cnt  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_fail  out  N_IN  first vector that mismatched; 0 if none.

## Operation

- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE: if start=1 and abort=0, go to HOLD. On entry set in_vec=0, clear fail_cnt, first_fail and pass, and load the settle counter with SETTLE.
- HOLD: decrement the settle counter each cycle; in_vec stays stable. Go to SAMPLE when the counter reaches 1.
- SAMPLE: compare y_in with EXP_TT[in_vec].
  - On mismatch: increment fail_cnt. If this is the first mismatch of the sweep, capture in_vec into first_fail.
  - If in_vec is the last vector (all ones), go to DONE.
  - Otherwise increment in_vec, reload the counter and go to HOLD.
- DONE: assert done and set pass = (fail_cnt==0) for one cycle, then go to IDLE.
- in_vec never wraps within a sweep. After DONE it stays at all-ones until the next accepted start.
- abort=1 in HOLD or SAMPLE: go to IDLE next cycle with no done pulse; pass stays 0. fail_cnt and first_fail keep their partial values.
- start while busy, or in the DONE cycle: ignored.
- start and abort in the same IDLE cycle: abort wins, nothing starts.
- Reset values: in_vec=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail=0, state IDLE.
- rst asserted mid-sweep: all outputs go to their reset values immediately; the sweep is lost.

## Timing

- t0 is the cycle in which start is sampled high in IDLE.
- Vector k is driven from t0+1+k*(SETTLE+1) and sampled in cycle t0+(k+1)*(SETTLE+1).
- done is high in cycle t0+2**N_IN*(SETTLE+1)+1. busy is high from t0+1 through the cycle before done.
- Earliest next accepted start is the cycle after done.
- Latency with N_IN=2, SETTLE=1: done at t0+9.
- y_in is treated as combinational from in_vec; SETTLE covers any registering inside the gate wrapper.

## Structure

- Shared package gate_sweep_pkg holds:
  - the state enum;
  - truth-table constants for N_IN=2: TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One sub-module, sweep_settle_timer, is natural: a loadable down-counter of width clog2(SETTLE+1) with a load input and an expire output.
- The FSM, vector counter and checker live in gate_sweep_ctrl.

## Test plan

- NOR gate, defaults, start at t0:
  - in_vec = 00, 01, 10, 11, each held 2 cycles;
  - done at t0+9; pass=1, fail_cnt=0, first_fail=0.
- Gate swapped to NAND, EXP_TT=TT_NOR:
  - y = 1, 1, 1, 0 against expected 1, 0, 0, 0;
  - fail_cnt=3, first_fail=2'b01, pass=0.
- start re-pulsed at t0+3 during a sweep: ignored; exactly one done pulse, at t0+9.
- abort at t0+4:
  - busy low from t0+5, no done, pass=0;
  - a following start runs a full clean sweep with pass=1.
- rst pulsed asynchronously mid-cycle at t0+5:
  - all outputs 0 immediately;
  - after release, start yields a normal sweep with done 9 cycles later.
- SETTLE=3 with the NOR gate: each vector held 4 cycles; done at t0+17; pass=1.
